sdram_arbit: RTL and testbench

Command arbiter inside the SDRAM controller. It sequences power-up init, auto-refresh, write bursts and read bursts onto the single SDRAM command/address bus. It grants one sub-engine at a time and muxes that engine's command, bank and address onto the bus. It signals pending refresh to the active burst engine and guards against a hung engine with a timeout.

---
 rtl/sdram_arbit.sv | 164 ++++++++++++++++
 tb/tb_sdram_arbit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arbit
//  Purpose  : Command arbiter for the SDRAM controller. It sequences the
//             power-up init engine, then grants one engine at a time
//             (refresh, write burst or read burst). The granted engine's
//             command, bank and address are muxed onto the single SDRAM bus.
//             A hung engine is released by a grant timeout.
//  Ports    : sys_clk / sys_rst_n        clock, synchronous active-low reset
//             init_*                     init engine done level, cmd, addr
//             aref_*                     refresh request, done, cmd, addr
//             wr_* / rd_*                burst request, done, cmd, bank, addr
//             aref_en / wr_en / rd_en    registered grants
//             aref_pend                  refresh waiting behind a burst
//             sdram_cmd/bank/addr        muxed SDRAM command bus
//             arb_err                    1-cycle pulse on grant timeout
//  Revision : 1.0  initial release
// ============================================================================
module sdram_arbit #(
    parameter int ADDR_BITS = 12,
    parameter int BA_BITS   = 2,
    parameter int TIMEOUT   = 1024,
    parameter int TO_BITS   = 10
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 init_done,
    input  logic [3:0]           init_cmd,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic                 aref_req,
    input  logic                 aref_done,
    input  logic [3:0]           aref_cmd,
    input  logic [ADDR_BITS-1:0] aref_addr,
    input  logic                 wr_req,
    input  logic                 wr_done,
    input  logic [3:0]           wr_cmd,
    input  logic [BA_BITS-1:0]   wr_bank,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic                 rd_req,
    input  logic                 rd_done,
    input  logic [3:0]           rd_cmd,
    input  logic [BA_BITS-1:0]   rd_bank,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 aref_en,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic                 aref_pend,
    output logic [3:0]           sdram_cmd,
    output logic [BA_BITS-1:0]   sdram_bank,
    output logic [ADDR_BITS-1:0] sdram_addr,
    output logic                 arb_err
);

    localparam logic [3:0] C_CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_last_wr;
    logic [TO_BITS-1:0]   r_to_cnt;
    logic                 r_arb_err;
    logic                 w_err;
    logic                 w_granted;
    logic                 w_timeout;

    assign w_granted = (r_state == S_AREF) || (r_state == S_WRITE) || (r_state == S_READ);
    assign w_timeout = (r_to_cnt == TO_BITS'(TIMEOUT - 1));

    // Next-state logic. A done pulse is checked before the timeout so that
    // a burst finishing on its last allowed cycle is not flagged.
    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            S_INIT: begin
                if (init_done) w_next = S_IDLE;
            end
            S_IDLE: begin
                if (aref_req)
                    w_next = S_AREF;
                else if (wr_req && (!rd_req || !r_last_wr))
                    w_next = S_WRITE;
                else if (rd_req)
                    w_next = S_READ;
            end
            S_AREF: begin
                if (aref_done)      w_next = S_IDLE;
                else if (w_timeout) begin w_next = S_IDLE; w_err = 1'b1; end
            end
            S_WRITE: begin
                if (wr_done)        w_next = S_IDLE;
                else if (w_timeout) begin w_next = S_IDLE; w_err = 1'b1; end
            end
            S_READ: begin
                if (rd_done)        w_next = S_IDLE;
                else if (w_timeout) begin w_next = S_IDLE; w_err = 1'b1; end
            end
            default: w_next = S_INIT;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state   <= S_INIT;
            r_last_wr <= 1'b0;
            r_to_cnt  <= '0;
            r_arb_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_arb_err <= w_err;
            if (r_state == S_IDLE && w_next == S_WRITE) r_last_wr <= 1'b1;
            if (r_state == S_IDLE && w_next == S_READ)  r_last_wr <= 1'b0;
            // Every grant is entered from idle, so clearing outside grant
            // states gives a fresh count per grant; saturates at the limit.
            if (!w_granted)
                r_to_cnt <= '0;
            else if (!w_timeout)
                r_to_cnt <= r_to_cnt + TO_BITS'(1);
        end
    end

    assign aref_en   = (r_state == S_AREF);
    assign wr_en     = (r_state == S_WRITE);
    assign rd_en     = (r_state == S_READ);
    assign arb_err   = r_arb_err;
    assign aref_pend = aref_req && ((r_state == S_WRITE) || (r_state == S_READ));

    // Command bus mux; idle drives NOP with bank/address at zero.
    always_comb begin
        sdram_cmd  = C_CMD_NOP;
        sdram_bank = '0;
        sdram_addr = '0;
        case (r_state)
            S_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            S_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            S_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_bank = wr_bank;
                sdram_addr = wr_addr;
            end
            S_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_arbit
//  Purpose  : Self-checking bench for sdram_arbit. A cycle-level reference
//             model tracks which engine owns the bus and how long it has
//             held it; every cycle all DUT outputs are compared against it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdram_arbit;

    localparam int AB  = 12;
    localparam int BB  = 2;
    localparam int TMO = 16;
    localparam int TOB = 5;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          init_done = 1'b0;
    logic [3:0]    init_cmd = '0;
    logic [AB-1:0] init_addr = '0;
    logic          aref_req = 1'b0, aref_done = 1'b0;
    logic [3:0]    aref_cmd = '0;
    logic [AB-1:0] aref_addr = '0;
    logic          wr_req = 1'b0, wr_done = 1'b0;
    logic [3:0]    wr_cmd = '0;
    logic [BB-1:0] wr_bank = '0;
    logic [AB-1:0] wr_addr = '0;
    logic          rd_req = 1'b0, rd_done = 1'b0;
    logic [3:0]    rd_cmd = '0;
    logic [BB-1:0] rd_bank = '0;
    logic [AB-1:0] rd_addr = '0;
    logic          aref_en, wr_en, rd_en, aref_pend, arb_err;
    logic [3:0]    sdram_cmd;
    logic [BB-1:0] sdram_bank;
    logic [AB-1:0] sdram_addr;

    sdram_arbit #(
        .ADDR_BITS(AB), .BA_BITS(BB), .TIMEOUT(TMO), .TO_BITS(TOB)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .init_done(init_done), .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_req(aref_req), .aref_done(aref_done), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_done(wr_done), .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_done(rd_done), .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .aref_pend(aref_pend),
        .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
        .arb_err(arb_err)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: owner -1 = powering up, 0 = nobody, 1 = refresh,
    // 2 = write, 3 = read. held = cycles the current owner has had the bus.
    int owner   = -1;
    int held    = 0;
    bit wlast   = 1'b0;
    bit err_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [3:0]    ecmd;
        logic [BB-1:0] ebank;
        logic [AB-1:0] eaddr;
        ecmd  = 4'b0111;
        ebank = '0;
        eaddr = '0;
        case (owner)
            -1: begin ecmd = init_cmd; eaddr = init_addr; end
            1:  begin ecmd = aref_cmd; eaddr = aref_addr; end
            2:  begin ecmd = wr_cmd; ebank = wr_bank; eaddr = wr_addr; end
            3:  begin ecmd = rd_cmd; ebank = rd_bank; eaddr = rd_addr; end
            default: ;
        endcase
        chk("grants", {29'd0, aref_en, wr_en, rd_en},
            {29'd0, owner == 1, owner == 2, owner == 3});
        chk("aref_pend", {31'd0, aref_pend}, {31'd0, aref_req && (owner == 2 || owner == 3)});
        chk("arb_err", {31'd0, arb_err}, {31'd0, err_exp});
        chk("cmd", {28'd0, sdram_cmd}, {28'd0, ecmd});
        chk("bank", {30'd0, sdram_bank}, {30'd0, ebank});
        chk("addr", {20'd0, sdram_addr}, {20'd0, eaddr});
    endtask

    task automatic model_update();
        bit done;
        if (!sys_rst_n) begin
            owner = -1; held = 0; wlast = 1'b0; err_exp = 1'b0;
        end else begin
            err_exp = 1'b0;
            if (owner == -1) begin
                if (init_done) owner = 0;
            end else if (owner == 0) begin
                held = 0;
                if (aref_req) owner = 1;
                else if (wr_req && !(rd_req && wlast)) begin owner = 2; wlast = 1'b1; end
                else if (rd_req) begin owner = 3; wlast = 1'b0; end
            end else begin
                done = (owner == 1) ? aref_done : (owner == 2) ? wr_done : rd_done;
                held++;
                if (done) owner = 0;
                else if (held == TMO) begin owner = 0; err_exp = 1'b1; end
            end
        end
    endtask

    task automatic new_data();
        init_cmd  = 4'($urandom); init_addr = AB'($urandom);
        aref_cmd  = 4'($urandom); aref_addr = AB'($urandom);
        wr_cmd    = 4'($urandom); wr_bank = BB'($urandom); wr_addr = AB'($urandom);
        rd_cmd    = 4'($urandom); rd_bank = BB'($urandom); rd_addr = AB'($urandom);
    endtask

    // One clock: check outputs mid-cycle, advance the model on the edge,
    // then present fresh engine data shortly after the edge.
    task automatic cycle();
        @(negedge sys_clk);
        check_outputs();
        @(posedge sys_clk);
        model_update();
        #1;
        new_data();
    endtask

    function automatic int dut_grant();
        return aref_en ? 1 : wr_en ? 2 : rd_en ? 3 : 0;
    endfunction

    task automatic wait_grant(output int who);
        for (int i = 0; i < 30 && owner < 1; i++) cycle();
        chk("grant_wait", {31'd0, owner >= 1}, 32'd1);
        who = dut_grant();
    endtask

    // The owning engine pulses its done; refresh drops its request with it.
    task automatic finish();
        case (owner)
            1: begin aref_done = 1'b1; aref_req = 1'b0; end
            2: wr_done = 1'b1;
            3: rd_done = 1'b1;
            default: ;
        endcase
        cycle();
        aref_done = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
    endtask

    task automatic burst(input int len, output int who);
        wait_grant(who);
        repeat (len) cycle();
        finish();
    endtask

    initial begin
        int who;
        new_data();
        @(posedge sys_clk);
        model_update();
        #1;
        repeat (2) cycle();
        sys_rst_n = 1'b1;

        // Power-up: init engine owns the bus until init_done
        repeat (20) cycle();
        chk("init_no_grant", {29'd0, aref_en, wr_en, rd_en}, 32'd0);
        init_done = 1'b1;
        cycle();
        chk("idle_nop", {28'd0, sdram_cmd}, 32'h7);

        // All three requests together: refresh, then write, then read
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        burst(3, who); chk("prio_aref", who, 1);
        burst(4, who); chk("prio_wr", who, 2);
        burst(2, who); chk("fair_rd", who, 3);

        // Both bursts pending: strict alternation
        for (int i = 0; i < 6; i++) begin
            burst(2 + i, who);
            chk("alternate", who, (i % 2 == 0) ? 2 : 3);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        cycle();

        // Refresh arriving mid-write waits, then beats the pending read
        wr_req = 1'b1; rd_req = 1'b1;
        wait_grant(who); chk("pend_wr", who, 2);
        repeat (3) cycle();
        aref_req = 1'b1;
        repeat (3) cycle();
        chk("pend_flag", {31'd0, aref_pend}, 32'd1);
        wr_req = 1'b0;
        finish();
        wait_grant(who); chk("pend_aref_first", who, 1);
        finish();
        wait_grant(who); chk("pend_rd_after", who, 3);
        rd_req = 1'b0;
        finish();
        cycle();

        // Hung read engine: released after TMO cycles with an error pulse
        rd_req = 1'b1;
        wait_grant(who); chk("to_grant", who, 3);
        rd_req = 1'b0;
        repeat (TMO) cycle();
        chk("to_rd_drop", {31'd0, rd_en}, 32'd0);
        chk("to_err", {31'd0, arb_err}, 32'd1);
        cycle();
        chk("to_err_pulse", {31'd0, arb_err}, 32'd0);
        wr_req = 1'b1;
        burst(3, who); chk("to_recover", who, 2);
        wr_req = 1'b0;
        cycle();

        // Reset in the middle of a write
        wr_req = 1'b1;
        wait_grant(who); chk("rst_wr", who, 2);
        repeat (2) cycle();
        sys_rst_n = 1'b0; init_done = 1'b0;
        cycle();
        chk("rst_drop", {31'd0, wr_en}, 32'd0);
        sys_rst_n = 1'b1;
        wr_done = 1'b1;
        cycle();
        wr_done = 1'b0;
        chk("rst_done_ignored", {29'd0, aref_en, wr_en, rd_en}, 32'd0);
        init_done = 1'b1;
        cycle();
        finish();
        wr_req = 1'b0;
        cycle();

        // Random traffic, including stray done pulses and occasional hangs
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) aref_req = ~aref_req;
            if ($urandom_range(0, 4) == 0) wr_req = ~wr_req;
            if ($urandom_range(0, 4) == 0) rd_req = ~rd_req;
            aref_done = ($urandom_range(0, 5) == 0);
            wr_done   = ($urandom_range(0, 5) == 0);
            rd_done   = ($urandom_range(0, 7) == 0);
            cycle();
        end
        aref_done = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
